// File: rtl/edge_tile_scheduler.sv
// Tile scheduler: walks a frame in 3x3-output tiles, fetches each 5x5 window, drives edge_detection_core and writes 9 results.
// Optional macro TILE_TIMEOUT_EN adds a WAIT-state watchdog and the sticky o_timeout output.
module edge_tile_scheduler #(
    parameter int IMG_WIDTH  = 428,
    parameter int IMG_HEIGHT = 428,
    parameter int ADDR_W     = 18,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_frame_start,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic [199:0]      o_win,
    output logic              o_gradient_start,
    input  logic              i_gradient_ready,
    input  logic [71:0]       i_processed_sum,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data
`ifdef TILE_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LP_W        = ADDR_W'(IMG_WIDTH);
    localparam logic [ADDR_W-1:0] LP_W_M4     = ADDR_W'(IMG_WIDTH - 4);
    localparam logic [ADDR_W-1:0] LP_W_M2     = ADDR_W'(IMG_WIDTH - 2);
    localparam logic [ADDR_W-1:0] LP_W_P1     = ADDR_W'(IMG_WIDTH + 1);
    localparam logic [ADDR_W-1:0] LP_COL_LAST = ADDR_W'(IMG_WIDTH - 5);
    localparam logic [ADDR_W-1:0] LP_ROW_LAST = ADDR_W'(IMG_HEIGHT - 5);
    localparam logic [ADDR_W-1:0] LP_STEP     = ADDR_W'(3);

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [2:0]        r_kx;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_base;
    logic [71:0]       r_sum;

    logic              w_col_end;
    logic              w_row_end;
    logic [ADDR_W-1:0] w_next_col;
    logic [ADDR_W-1:0] w_next_row;
    logic [ADDR_W-1:0] w_adv_row;
    logic [ADDR_W-1:0] w_adv_col;
    logic [ADDR_W-1:0] w_adv_base;
    logic [7:0]        w_byte_sel;
    logic [6:0]        w_sum_sel;

`ifdef TILE_TIMEOUT_EN
    localparam int LP_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LP_WAIT_W-1:0] LP_WAIT_LAST = LP_WAIT_W'(TIMEOUT - 1);
    logic [LP_WAIT_W-1:0] r_wait_cnt;
`endif

    // Next tile origin; a short final step to the last legal origin covers a non-3-aligned edge.
    always_comb begin
        w_col_end  = 1'b0;
        w_row_end  = 1'b0;
        w_next_col = '0;
        w_next_row = '0;
        if (r_col + LP_STEP <= LP_COL_LAST) begin
            w_next_col = r_col + LP_STEP;
        end else if (r_col != LP_COL_LAST) begin
            w_next_col = LP_COL_LAST;
        end else begin
            w_col_end = 1'b1;
        end
        if (r_row + LP_STEP <= LP_ROW_LAST) begin
            w_next_row = r_row + LP_STEP;
        end else if (r_row != LP_ROW_LAST) begin
            w_next_row = LP_ROW_LAST;
        end else begin
            w_row_end = 1'b1;
        end
        if (w_col_end) begin
            w_adv_row = w_next_row;
            w_adv_col = '0;
        end else begin
            w_adv_row = r_row;
            w_adv_col = w_next_col;
        end
        w_adv_base = w_adv_row * LP_W + w_adv_col;
        w_byte_sel = {r_cnt - 5'd1, 3'b000};
        w_sum_sel  = {r_cnt[3:0] + 4'd1, 3'b000};
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state          <= ST_IDLE;
            r_cnt            <= 5'd0;
            r_kx             <= 3'd0;
            r_row            <= '0;
            r_col            <= '0;
            r_base           <= '0;
            r_sum            <= 72'd0;
            o_busy           <= 1'b0;
            o_frame_done     <= 1'b0;
            o_rd_en          <= 1'b0;
            o_rd_addr        <= '0;
            o_win            <= 200'd0;
            o_gradient_start <= 1'b0;
            o_wr_en          <= 1'b0;
            o_wr_addr        <= '0;
            o_wr_data        <= 8'd0;
`ifdef TILE_TIMEOUT_EN
            r_wait_cnt       <= '0;
            o_timeout        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        r_state   <= ST_FETCH;
                        o_busy    <= 1'b1;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_base    <= '0;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= '0;
                        r_cnt     <= 5'd0;
                        r_kx      <= 3'd0;
`ifdef TILE_TIMEOUT_EN
                        o_timeout <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    // Read data lags the strobe by one cycle, so byte k lands while read k+1 is issued.
                    if (r_cnt != 5'd0) begin
                        o_win[w_byte_sel +: 8] <= i_rd_data;
                    end
                    if (r_cnt < 5'd24) begin
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= (r_kx == 3'd4) ? o_rd_addr + LP_W_M4 : o_rd_addr + 1'b1;
                        r_kx      <= (r_kx == 3'd4) ? 3'd0 : r_kx + 3'd1;
                    end else begin
                        o_rd_en   <= 1'b0;
                        o_rd_addr <= '0;
                    end
                    if (r_cnt == 5'd25) begin
                        r_state          <= ST_START;
                        o_gradient_start <= 1'b1;
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_START: begin
                    o_gradient_start <= 1'b0;
                    r_state          <= ST_WAIT;
`ifdef TILE_TIMEOUT_EN
                    r_wait_cnt       <= '0;
`endif
                end
                ST_WAIT: begin
                    if (i_gradient_ready) begin
                        r_sum     <= i_processed_sum;
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= r_base + LP_W_P1;
                        o_wr_data <= i_processed_sum[7:0];
                        r_cnt     <= 5'd0;
                        r_kx      <= 3'd0;
                        r_state   <= ST_WRITE;
                    end
`ifdef TILE_TIMEOUT_EN
                    else if (r_wait_cnt == LP_WAIT_LAST) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_base    <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                ST_WRITE: begin
                    if (r_cnt != 5'd8) begin
                        o_wr_addr <= (r_kx == 3'd2) ? o_wr_addr + LP_W_M2 : o_wr_addr + 1'b1;
                        r_kx      <= (r_kx == 3'd2) ? 3'd0 : r_kx + 3'd1;
                        o_wr_data <= r_sum[w_sum_sel +: 8];
                        r_cnt     <= r_cnt + 5'd1;
                    end else begin
                        o_wr_en   <= 1'b0;
                        o_wr_addr <= '0;
                        o_wr_data <= 8'd0;
                        r_state   <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    if (w_col_end && w_row_end) begin
                        o_frame_done <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_row     <= w_adv_row;
                        r_col     <= w_adv_col;
                        r_base    <= w_adv_base;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= w_adv_base;
                        r_cnt     <= 5'd0;
                        r_kx      <= 3'd0;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    o_frame_done <= 1'b0;
                    o_busy       <= 1'b0;
                    r_row        <= '0;
                    r_col        <= '0;
                    r_base       <= '0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_tile_scheduler.sv
// Scoreboard bench for edge_tile_scheduler on a 9x9 frame (non-3-aligned, exercises the extra origin).
module tb_edge_tile_scheduler;
    localparam int W  = 9;
    localparam int H  = 9;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          frame_start;
    logic          busy, frame_done, rd_en, gstart, gready, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0]    rd_data, wr_data;
    logic [199:0]  win;
    logic [71:0]   psum;
`ifdef TILE_TIMEOUT_EN
    logic          timeout;
`endif

    int n_pass = 0, n_fail = 0, done_cnt = 0, wr_cnt = 0, core_tile = 0, exp_tiles = 0;
    bit early_mode = 1'b0, core_off = 1'b0, track = 1'b1, prev_start = 1'b0;
    bit written [W*H];
    logic [AW-1:0]   exp_rd [$];
    logic [199:0]    exp_win [$];
    logic [AW+7:0]   exp_wr [$];

    edge_tile_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .TIMEOUT(16)) dut (
        .clk(clk), .n_rst(n_rst), .i_frame_start(frame_start), .o_busy(busy),
        .o_frame_done(frame_done), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_win(win), .o_gradient_start(gstart), .i_gradient_ready(gready),
        .i_processed_sum(psum), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
`ifdef TILE_TIMEOUT_EN
        , .o_timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    // Pixel memory: pixel(a) = a[7:0], one-cycle read latency.
    always @(posedge clk) rd_data <= rd_en ? rd_addr[7:0] : 8'hA5;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model: ready 3 cycles after start with sum_k = tile*10+k; early mode adds a bogus ready in START.
    initial begin
        gready = 1'b0;
        psum   = 72'd0;
        forever begin
            @(negedge clk);
            if (gstart === 1'b1 && !core_off) begin
                int t;
                t = core_tile;
                core_tile++;
                if (early_mode) begin
                    gready = 1'b1;
                    psum   = {9{8'hEE}};
                    @(negedge clk);
                    gready = 1'b0;
                    repeat (4) @(negedge clk);
                end else begin
                    repeat (3) @(negedge clk);
                end
                for (int k = 0; k < 9; k++) psum[8*k +: 8] = 8'(t*10 + k + 1);
                gready = 1'b1;
                @(negedge clk);
                gready = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every read, start and write.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                wr_cnt++;
                if (int'(wr_addr) < W*H) written[wr_addr] = 1'b1;
                if (exp_wr.size() == 0) check("wr_extra", wr_en, 1'b0);
                else check("wr", {wr_addr, wr_data}, exp_wr.pop_front());
            end
            if (rd_en === 1'b1 && track) begin
                if (exp_rd.size() == 0) check("rd_extra", rd_en, 1'b0);
                else check("rd_addr", rd_addr, exp_rd.pop_front());
            end
            if (gstart === 1'b1 && track) begin
                if (exp_win.size() == 0) check("start_extra", gstart, 1'b0);
                else check("win", win, exp_win.pop_front());
            end
            if (prev_start) check("start_pulse", gstart, 1'b0);
            prev_start = (gstart === 1'b1);
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    task automatic push_frame();
        int cols [$];
        int rows [$];
        int t, a;
        logic [199:0] w;
        for (int c = 0; c <= W-5; c += 3) cols.push_back(c);
        if ((W-2) % 3 != 0) cols.push_back(W-5);
        for (int r = 0; r <= H-5; r += 3) rows.push_back(r);
        if ((H-2) % 3 != 0) rows.push_back(H-5);
        exp_rd.delete();
        exp_win.delete();
        exp_wr.delete();
        foreach (written[i]) written[i] = 1'b0;
        t = 0;
        foreach (rows[ri]) begin
            foreach (cols[ci]) begin
                w = '0;
                for (int k = 0; k < 25; k++) begin
                    a = (rows[ri] + k/5)*W + cols[ci] + k%5;
                    exp_rd.push_back(AW'(a));
                    w[8*k +: 8] = 8'(a);
                end
                exp_win.push_back(w);
                for (int k = 0; k < 9; k++) begin
                    a = (rows[ri] + 1 + k/3)*W + cols[ci] + 1 + k%3;
                    exp_wr.push_back({AW'(a), 8'(t*10 + k + 1)});
                end
                t++;
            end
        end
        exp_tiles = t;
        core_tile = 0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", int'(done_cnt != d0), 1);
    endtask

    task automatic frame_checks(input int d0, input int w0);
        int inner, border;
        repeat (4) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("write_count", wr_cnt - w0, exp_tiles*9);
        check("queues_empty", exp_rd.size() + exp_win.size() + exp_wr.size(), 0);
        inner  = 0;
        border = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (written[r*W + c]) begin
                    if (r == 0 || c == 0 || r == H-1 || c == W-1) border++;
                    else inner++;
                end
        check("interior_cover", inner, (W-2)*(H-2));
        check("border_untouched", border, 0);
        check("idle_busy", busy, 1'b0);
    endtask

    function automatic logic [255:0] all_outs();
        return {busy, frame_done, rd_en, rd_addr, win, gstart, wr_en, wr_addr, wr_data};
    endfunction

    initial begin
        int d0, w0, n;
        n_rst       = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), '0);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", busy, 1'b0);

        // Normal frame, with a stray frame_start while busy.
        push_frame();
        check("tile_count", exp_tiles, 9);
        d0 = done_cnt;
        w0 = wr_cnt;
        start_frame();
        check("busy_after_start", busy, 1'b1);
        repeat (40) @(negedge clk);
        start_frame();
        wait_done(d0);
        frame_checks(d0, w0);

        // Ready pulse during START must be ignored; the later one is accepted.
        early_mode = 1'b1;
        push_frame();
        d0 = done_cnt;
        w0 = wr_cnt;
        start_frame();
        wait_done(d0);
        frame_checks(d0, w0);
        early_mode = 1'b0;

        // Reset during the second tile's WRITE aborts the frame.
        push_frame();
        w0 = wr_cnt;
        start_frame();
        n = 0;
        while (wr_cnt - w0 < 11 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_tile2_write", wr_en, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("abort_outs", all_outs(), '0);
        exp_rd.delete();
        exp_win.delete();
        exp_wr.delete();
        w0 = wr_cnt;
        repeat (80) @(negedge clk);
        check("no_wr_after_abort", wr_cnt - w0, 0);
        check("idle_after_abort", busy, 1'b0);

        // Restart from origin (0,0) after the abort.
        push_frame();
        d0 = done_cnt;
        w0 = wr_cnt;
        start_frame();
        wait_done(d0);
        frame_checks(d0, w0);

`ifdef TILE_TIMEOUT_EN
        check("timeout_idle", timeout, 1'b0);
        core_off = 1'b1;
        track    = 1'b0;
        push_frame();
        exp_wr.delete();
        d0 = done_cnt;
        w0 = wr_cnt;
        start_frame();
        repeat (42) @(negedge clk);
        check("timeout_not_yet", timeout, 1'b0);
        @(negedge clk);
        check("timeout_set", timeout, 1'b1);
        check("timeout_idle_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check("timeout_no_writes", wr_cnt - w0, 0);
        check("timeout_no_done", done_cnt - d0, 0);
        start_frame();
        check("timeout_cleared", timeout, 1'b0);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst    = 1'b1;
        core_off = 1'b0;
        track    = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule

// File: doc/edge_tile_scheduler.md
Name: edge_tile_scheduler

Overview:
- Initiator side of the edge_detection_core window handshake.
- Walks a grayscale frame in pixel memory in 3x3-output tiles. For each tile it fetches the 5x5 source window, presents it to the core with a one-cycle start pulse, waits for ready, and writes the 9 processed pixels to result memory.
- Sits between the frame buffer and edge_detection_core. Replaces software/bench-driven window feeding in the full-chip path.

Parameters:
- IMG_WIDTH, 428, frame width in pixels (>=5)
- IMG_HEIGHT, 428, frame height in pixels (>=5)
- ADDR_W, 18, pixel address width; must hold IMG_WIDTH*IMG_HEIGHT-1
- TIMEOUT, 1024, WAIT-state watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- i_frame_start  in  1  single-cycle pulse; starts a frame when IDLE
- o_busy  out  1  high in every state except IDLE
- o_frame_done  out  1  one-cycle pulse after the last tile's last write
- o_rd_en  out  1  pixel memory read strobe
- o_rd_addr  out  ADDR_W  pixel read address, row*IMG_WIDTH+col
- i_rd_data  in  8  read data, valid exactly 1 cycle after o_rd_en
- o_win  out  200  5x5 window, row-major; m1 in [7:0], m25 in [199:192]
- o_gradient_start  out  1  one-cycle start pulse to the core
- i_gradient_ready  in  1  core result valid
- i_processed_sum  in  72  9 results; sum_1 in [7:0], sum_9 in [71:64]
- o_wr_en  out  1  result memory write strobe
- o_wr_addr  out  ADDR_W  result write address
- o_wr_data  out  8  result pixel

Behaviour:
- Reset (n_rst=0 at a clk edge): state=IDLE. All outputs 0, including o_win. Tile origin (r,c)=(0,0). Reset mid-frame aborts with no further reads or writes.
- Tile origins: c steps 0,3,6,... while c<=IMG_WIDTH-5. If (IMG_WIDTH-2)%3!=0, one extra final column origin c=IMG_WIDTH-5 is used, so overlapping outputs are rewritten with identical values. Rows r follow the same rule with IMG_HEIGHT. Order is row-major: c inner, r outer.
- IDLE: i_frame_start=1 -> FETCH.
- FETCH: 25 reads on consecutive cycles, k=0..24, o_rd_addr=(r+k/5)*IMG_WIDTH+c+k%5. i_rd_data is captured into o_win byte k one cycle later. Takes 26 cycles, then -> START.
- START: o_gradient_start=1 for exactly 1 cycle -> WAIT.
- WAIT: i_gradient_ready is sampled from the cycle after START. Ready seen -> capture i_processed_sum -> WRITE. Ready during START is ignored.
- o_win holds stable from the end of FETCH until the next FETCH begins.
- WRITE: 9 writes on consecutive cycles, k=0..8, o_wr_addr=(r+1+k/3)*IMG_WIDTH+c+1+k%3, o_wr_data=captured sum_(k+1). Then -> ADVANCE.
- ADVANCE (1 cycle): step c. At the column end, c=0 and step r. Past the last row -> DONE; otherwise -> FETCH.
- DONE: o_frame_done=1 for 1 cycle -> IDLE.
- i_frame_start while busy: ignored.
- Per-tile latency: 26+1+L+9+1 cycles, where L is the core response in cycles (>=1).
- Border pixels (row 0, row H-1, col 0, col W-1) are never written.
- Address arithmetic is unsigned ADDR_W with no wrap. The parameter check is the integrator's responsibility.

Optional Feature:
- TILE_TIMEOUT_EN defined:
  - Adds output o_timeout (1 bit, reset 0).
  - A counter runs in WAIT. If ready is not seen within TIMEOUT cycles, o_timeout is set sticky, the FSM goes to IDLE with no writes for that tile, and o_frame_done is not pulsed.
  - o_timeout clears only on reset or the next accepted i_frame_start.
- Undefined: no o_timeout port, no counter; WAIT waits indefinitely.

Test Plan:
- W=H=8, pixel(a)=a[7:0], core model returns ready 3 cycles after start with sum_k=k. Required: 4 tiles, origins (0,0),(0,3),(3,0),(3,3); 36 writes; wr_addr 9,10,11,17,18,19,25,26,27 with data 1..9 for the first tile; o_frame_done exactly once.
- Same frame, first tile: o_rd_addr sequence 0,1,2,3,4,8,...,36. o_win[7:0]=0, o_win[199:192]=36 at START. o_gradient_start high exactly 1 cycle.
- W=H=9 (not 3-aligned): origins columns 0,3,4 and rows 0,3,4. Required: 9 tiles and o_frame_done; every interior pixel (1..7, 1..7) written.
- Ready asserted during the START cycle and held 1 cycle only: required no capture, the FSM remains in WAIT. A second ready 5 cycles later is accepted.
- n_rst=0 during WRITE of tile 2: required all outputs 0 the next cycle with no further writes. A new i_frame_start restarts at origin (0,0).
- TILE_TIMEOUT_EN, TIMEOUT=16, core never ready: o_timeout=1 at the 16th WAIT cycle, FSM IDLE, no writes, no o_frame_done. i_frame_start clears o_timeout.
